// File: rtl/exe_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : exe_stage_pipe
//  Description : Execute stage of the 5-stage ARM core. Holds the ID/EX and
//                EX/MEM registers, the ALU, the NZCV status register and the
//                branch-target resolution.
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_stall_in,
    input  logic              bubble_in,
    input  logic              id_valid_in,
    input  logic [3:0]        id_exe_cmd_in,
    input  logic              id_s_in,
    input  logic              id_b_in,
    input  logic              id_mem_r_en_in,
    input  logic              id_mem_w_en_in,
    input  logic              id_wb_en_in,
    input  logic [PC_W-1:0]   id_pc_in,
    input  logic [DATA_W-1:0] id_val_rn_in,
    input  logic [DATA_W-1:0] id_val2_in,
    input  logic [DATA_W-1:0] id_val_rm_in,
    input  logic [3:0]        id_dest_in,
    input  logic [23:0]       id_imm24_in,
    output logic              br_taken_out,
    output logic [PC_W-1:0]   br_addr_out,
    output logic [3:0]        status_out,
    output logic              ex_valid_out,
    output logic              ex_wb_en_out,
    output logic              ex_mem_r_en_out,
    output logic              ex_mem_w_en_out,
    output logic [DATA_W-1:0] ex_alu_res_out,
    output logic [DATA_W-1:0] ex_val_rm_out,
    output logic [3:0]        ex_dest_out
);

    localparam logic [3:0] c_cmd_mov = 4'b0001;
    localparam logic [3:0] c_cmd_mvn = 4'b1001;
    localparam logic [3:0] c_cmd_add = 4'b0010;
    localparam logic [3:0] c_cmd_adc = 4'b0011;
    localparam logic [3:0] c_cmd_sub = 4'b0100;
    localparam logic [3:0] c_cmd_sbc = 4'b0101;
    localparam logic [3:0] c_cmd_and = 4'b0110;
    localparam logic [3:0] c_cmd_orr = 4'b0111;
    localparam logic [3:0] c_cmd_eor = 4'b1000;

    logic              r_idex_valid, r_idex_s, r_idex_b;
    logic              r_idex_mem_r_en, r_idex_mem_w_en, r_idex_wb_en;
    logic [3:0]        r_idex_cmd, r_idex_dest;
    logic [PC_W-1:0]   r_idex_pc;
    logic [DATA_W-1:0] r_idex_rn, r_idex_val2, r_idex_rm;
    logic [23:0]       r_idex_imm24;
    logic [3:0]        r_status;

    logic              r_ex_valid, r_ex_wb_en, r_ex_mem_r_en, r_ex_mem_w_en;
    logic [DATA_W-1:0] r_ex_alu_res, r_ex_val_rm;
    logic [3:0]        r_ex_dest;

    logic              w_arith, w_sub, w_cin, w_ovf;
    logic [DATA_W-1:0] w_op_b, w_alu_res;
    logic [DATA_W:0]   w_sum;
    logic [PC_W-1:0]   w_br_offset;

    always_ff @(posedge clk) begin
        if (rst || (!mem_stall_in && bubble_in)) begin
            r_idex_valid    <= 1'b0;
            r_idex_s        <= 1'b0;
            r_idex_b        <= 1'b0;
            r_idex_mem_r_en <= 1'b0;
            r_idex_mem_w_en <= 1'b0;
            r_idex_wb_en    <= 1'b0;
            r_idex_cmd      <= '0;
            r_idex_dest     <= '0;
            r_idex_pc       <= '0;
            r_idex_rn       <= '0;
            r_idex_val2     <= '0;
            r_idex_rm       <= '0;
            r_idex_imm24    <= '0;
        end else if (!mem_stall_in) begin
            // Control bits are qualified by valid so an empty slot can never write or branch
            r_idex_valid    <= id_valid_in;
            r_idex_s        <= id_s_in & id_valid_in;
            r_idex_b        <= id_b_in & id_valid_in;
            r_idex_mem_r_en <= id_mem_r_en_in & id_valid_in;
            r_idex_mem_w_en <= id_mem_w_en_in & id_valid_in;
            r_idex_wb_en    <= id_wb_en_in & id_valid_in;
            r_idex_cmd      <= id_exe_cmd_in;
            r_idex_dest     <= id_dest_in;
            r_idex_pc       <= id_pc_in;
            r_idex_rn       <= id_val_rn_in;
            r_idex_val2     <= id_val2_in;
            r_idex_rm       <= id_val_rm_in;
            r_idex_imm24    <= id_imm24_in;
        end
    end

    always_comb begin
        w_arith = 1'b0;
        w_sub   = 1'b0;
        w_cin   = 1'b0;
        case (r_idex_cmd)
            c_cmd_add: w_arith = 1'b1;
            c_cmd_adc: begin w_arith = 1'b1; w_cin = r_status[1]; end
            c_cmd_sub: begin w_arith = 1'b1; w_sub = 1'b1; w_cin = 1'b1; end
            c_cmd_sbc: begin w_arith = 1'b1; w_sub = 1'b1; w_cin = r_status[1]; end
            default:   ;
        endcase
    end

    // Subtraction is rn + ~val2 + cin, so the carry out is the inverted borrow
    assign w_op_b = w_sub ? ~r_idex_val2 : r_idex_val2;
    assign w_sum  = {1'b0, r_idex_rn} + {1'b0, w_op_b} + {{DATA_W{1'b0}}, w_cin};
    assign w_ovf  = (r_idex_rn[DATA_W-1] == w_op_b[DATA_W-1]) &&
                    (w_sum[DATA_W-1] != r_idex_rn[DATA_W-1]);

    always_comb begin
        w_alu_res = r_idex_val2;
        case (r_idex_cmd)
            c_cmd_mov: w_alu_res = r_idex_val2;
            c_cmd_mvn: w_alu_res = ~r_idex_val2;
            c_cmd_add, c_cmd_adc,
            c_cmd_sub, c_cmd_sbc: w_alu_res = w_sum[DATA_W-1:0];
            c_cmd_and: w_alu_res = r_idex_rn & r_idex_val2;
            c_cmd_orr: w_alu_res = r_idex_rn | r_idex_val2;
            c_cmd_eor: w_alu_res = r_idex_rn ^ r_idex_val2;
            default:   w_alu_res = r_idex_val2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= 4'b0000;
        end else if (!mem_stall_in && r_idex_valid && r_idex_s) begin
            r_status[3] <= w_alu_res[DATA_W-1];
            r_status[2] <= (w_alu_res == '0);
            if (w_arith) begin
                r_status[1] <= w_sum[DATA_W];
                r_status[0] <= w_ovf;
            end
        end
    end

    // Branches and bubbles retire as empty slots
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_wb_en    <= 1'b0;
            r_ex_mem_r_en <= 1'b0;
            r_ex_mem_w_en <= 1'b0;
            r_ex_alu_res  <= '0;
            r_ex_val_rm   <= '0;
            r_ex_dest     <= '0;
        end else if (!mem_stall_in) begin
            r_ex_valid    <= r_idex_valid & ~r_idex_b;
            r_ex_wb_en    <= r_idex_wb_en & ~r_idex_b;
            r_ex_mem_r_en <= r_idex_mem_r_en & ~r_idex_b;
            r_ex_mem_w_en <= r_idex_mem_w_en & ~r_idex_b;
            r_ex_alu_res  <= w_alu_res;
            r_ex_val_rm   <= r_idex_rm;
            r_ex_dest     <= r_idex_dest;
        end
    end

    assign w_br_offset     = {{(PC_W-26){r_idex_imm24[23]}}, r_idex_imm24, 2'b00};
    assign br_taken_out    = r_idex_valid & r_idex_b;
    assign br_addr_out     = r_idex_pc + w_br_offset;
    assign status_out      = r_status;
    assign ex_valid_out    = r_ex_valid;
    assign ex_wb_en_out    = r_ex_wb_en;
    assign ex_mem_r_en_out = r_ex_mem_r_en;
    assign ex_mem_w_en_out = r_ex_mem_w_en;
    assign ex_alu_res_out  = r_ex_alu_res;
    assign ex_val_rm_out   = r_ex_val_rm;
    assign ex_dest_out     = r_ex_dest;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_stage_pipe
//  Description : Directed self-checking bench for exe_stage_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, mem_stall_in, bubble_in, id_valid_in;
    logic [3:0]  id_exe_cmd_in;
    logic        id_s_in, id_b_in, id_mem_r_en_in, id_mem_w_en_in, id_wb_en_in;
    logic [31:0] id_pc_in, id_val_rn_in, id_val2_in, id_val_rm_in;
    logic [3:0]  id_dest_in;
    logic [23:0] id_imm24_in;
    logic        br_taken_out;
    logic [31:0] br_addr_out;
    logic [3:0]  status_out;
    logic        ex_valid_out, ex_wb_en_out, ex_mem_r_en_out, ex_mem_w_en_out;
    logic [31:0] ex_alu_res_out, ex_val_rm_out;
    logic [3:0]  ex_dest_out;

    int n_pass  = 0;
    int n_total = 0;

    exe_stage_pipe #(.DATA_W(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .mem_stall_in(mem_stall_in), .bubble_in(bubble_in),
        .id_valid_in(id_valid_in), .id_exe_cmd_in(id_exe_cmd_in),
        .id_s_in(id_s_in), .id_b_in(id_b_in),
        .id_mem_r_en_in(id_mem_r_en_in), .id_mem_w_en_in(id_mem_w_en_in),
        .id_wb_en_in(id_wb_en_in), .id_pc_in(id_pc_in),
        .id_val_rn_in(id_val_rn_in), .id_val2_in(id_val2_in),
        .id_val_rm_in(id_val_rm_in), .id_dest_in(id_dest_in),
        .id_imm24_in(id_imm24_in),
        .br_taken_out(br_taken_out), .br_addr_out(br_addr_out),
        .status_out(status_out), .ex_valid_out(ex_valid_out),
        .ex_wb_en_out(ex_wb_en_out), .ex_mem_r_en_out(ex_mem_r_en_out),
        .ex_mem_w_en_out(ex_mem_w_en_out), .ex_alu_res_out(ex_alu_res_out),
        .ex_val_rm_out(ex_val_rm_out), .ex_dest_out(ex_dest_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] cmd, input logic s, input logic b,
                         input logic mr, input logic mw, input logic wb,
                         input logic [31:0] rn, input logic [31:0] v2, input logic [31:0] rm,
                         input logic [3:0] dest);
        id_valid_in = v;    id_exe_cmd_in = cmd; id_s_in = s; id_b_in = b;
        id_mem_r_en_in = mr; id_mem_w_en_in = mw; id_wb_en_in = wb;
        id_val_rn_in = rn;  id_val2_in = v2;    id_val_rm_in = rm; id_dest_in = dest;
        id_pc_in = 32'h0;   id_imm24_in = 24'h0;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    // Issue one non-flag-setting op, flush it through and check the result
    task automatic alu_op(input string tag, input logic [3:0] cmd,
                          input logic [31:0] rn, input logic [31:0] v2, input logic [31:0] exp);
        drive(1'b1, cmd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rn, v2, 32'h0, 4'h9);
        tick();
        idle();
        tick();
        check(tag, ex_alu_res_out, exp);
    endtask

    initial begin
        rst = 1'b1; mem_stall_in = $urandom_range(0, 1); bubble_in = $urandom_range(0, 1);
        drive(1'b1, 4'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              $urandom, $urandom, $urandom, 4'($urandom));
        id_pc_in = $urandom; id_imm24_in = 24'($urandom);
        tick();
        tick();
        check("rst_status", status_out, 4'b0000);
        check("rst_br_taken", br_taken_out, 1'b0);
        check("rst_br_addr", br_addr_out, 32'h0);
        check("rst_ex_ctrl", {ex_valid_out, ex_wb_en_out, ex_mem_r_en_out, ex_mem_w_en_out}, 4'b0000);
        check("rst_ex_data", {ex_alu_res_out, ex_val_rm_out}, 64'h0);
        check("rst_ex_dest", ex_dest_out, 4'h0);

        rst = 1'b0; mem_stall_in = 1'b0; bubble_in = 1'b0;
        idle();
        tick();

        // ADDS overflow
        drive(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'd3);
        tick();
        idle();
        tick();
        check("adds_res", ex_alu_res_out, 32'h8000_0000);
        check("adds_wb_dest", {ex_valid_out, ex_wb_en_out, ex_dest_out}, {1'b1, 1'b1, 4'd3});
        check("adds_status", status_out, 4'b1001);

        // SUBS equal then ADC consuming the new carry
        drive(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 32'h0, 4'd1);
        tick();
        drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 32'h0, 4'd2);
        tick();
        check("subs_status", status_out, 4'b0110);
        check("subs_res", ex_alu_res_out, 32'h0);
        idle();
        tick();
        check("adc_res", ex_alu_res_out, 32'd3);
        check("adc_status_kept", status_out, 4'b0110);

        // Branch, then flush the following slot
        drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
        id_pc_in = 32'h100; id_imm24_in = 24'hFFFFFE;
        tick();
        check("b_taken", br_taken_out, 1'b1);
        check("b_addr", br_addr_out, 32'h0F8);
        drive(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1, 32'h0, 4'd4);
        bubble_in = 1'b1;
        tick();
        check("b_slot_ctrl", {ex_valid_out, ex_wb_en_out, ex_mem_r_en_out, ex_mem_w_en_out}, 4'b0000);
        check("b_taken_cleared", br_taken_out, 1'b0);
        bubble_in = 1'b0;
        idle();
        tick();
        check("bubble_slot_ctrl", {ex_valid_out, ex_wb_en_out, ex_mem_r_en_out, ex_mem_w_en_out}, 4'b0000);
        check("bubble_status_kept", status_out, 4'b0110);

        // STR, then ADDS held behind a 3-cycle stall, then ORR
        drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h8, 32'hAB, 4'h0);
        tick();
        drive(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2, 32'h0, 4'd5);
        tick();
        check("str_addr", ex_alu_res_out, 32'h48);
        check("str_ctrl", {ex_valid_out, ex_mem_w_en_out, ex_wb_en_out}, 3'b110);
        drive(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h01, 32'h0, 4'd6);
        mem_stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_data", i), {ex_alu_res_out, ex_val_rm_out}, {32'h48, 32'hAB});
            check($sformatf("stall%0d_mw", i), ex_mem_w_en_out, 1'b1);
            check($sformatf("stall%0d_status", i), status_out, 4'b0110);
        end
        mem_stall_in = 1'b0;
        tick();
        check("post_stall_adds", {ex_valid_out, ex_mem_w_en_out, ex_dest_out, ex_alu_res_out},
              {1'b1, 1'b0, 4'd5, 32'd3});
        check("post_stall_status", status_out, 4'b0000);
        idle();
        tick();
        check("post_stall_orr", {ex_valid_out, ex_dest_out, ex_alu_res_out}, {1'b1, 4'd6, 32'h11});
        tick();
        check("orr_once", ex_valid_out, 1'b0);

        // CMP then ANDS: logic op keeps C and V
        drive(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'h0, 4'd0);
        tick();
        drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0, 32'h0F, 32'h0, 4'd7);
        tick();
        check("cmp_status", status_out, 4'b1000);
        check("cmp_no_wb", {ex_valid_out, ex_wb_en_out}, 2'b10);
        idle();
        tick();
        check("ands_status", status_out, 4'b0100);
        check("ands_res", {ex_wb_en_out, ex_alu_res_out}, {1'b1, 32'h0});

        // Remaining ALU codes; C is 0 here, so SBC subtracts an extra 1
        alu_op("sbc_res", 4'b0101, 32'd10, 32'd3, 32'd6);
        alu_op("eor_res", 4'b1000, 32'hFF, 32'h0F, 32'hF0);
        alu_op("mvn_res", 4'b1001, 32'h0, 32'h0, 32'hFFFF_FFFF);
        alu_op("mov_res", 4'b0001, 32'h1234, 32'h55, 32'h55);
        alu_op("default_mov", 4'b1111, 32'h1234, 32'hA5, 32'hA5);

        // Reset while a branch is stalled in EX
        drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
        id_pc_in = 32'h200; id_imm24_in = 24'h000004;
        tick();
        check("b2_addr", br_addr_out, 32'h210);
        mem_stall_in = 1'b1; bubble_in = 1'b1; rst = 1'b1;
        tick();
        check("rst_stall_taken", br_taken_out, 1'b0);
        check("rst_stall_ex", {ex_valid_out, ex_alu_res_out}, 33'h0);
        rst = 1'b0; mem_stall_in = 1'b0; bubble_in = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
